// File: rtl/retire_trace_buffer.sv
// Retired-instruction trace capture: arm/trigger/length FSM feeding a circular
// buffer that drains through a valid/ready port, with drop counter and timestamp.
module retire_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int CNTW      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [31:0]              ret_instr,
    input  logic                     ret_rd_we,
    input  logic [4:0]               ret_rd,
    input  logic [XLEN-1:0]          ret_rd_data,
    input  logic                     ret_mem_we,
    input  logic [3:0]               ret_mem_sel,
    input  logic [XLEN-1:0]          ret_mem_addr,
    input  logic [XLEN-1:0]          ret_mem_data,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic [CNTW-1:0]          cap_len,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_rd_we,
    output logic [4:0]               out_rd,
    output logic [XLEN-1:0]          out_rd_data,
    output logic                     out_mem_we,
    output logic [3:0]               out_mem_sel,
    output logic [XLEN-1:0]          out_mem_addr,
    output logic [XLEN-1:0]          out_mem_data,
    output logic [31:0]              out_stamp,
    output logic [1:0]               state,
    output logic [CNTW-1:0]          drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            rdWe;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdData;
        logic            memWe;
        logic [3:0]      memSel;
        logic [XLEN-1:0] memAddr;
        logic [XLEN-1:0] memData;
        logic [31:0]     stamp;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          newEntry;
    entry_t          head;
    state_t          stateQ, stateNext;
    logic [PW-1:0]   wrPtr, rdPtr;
    logic [LW-1:0]   levelQ;
    logic [CNTW-1:0] dropQ, capCnt, capInc;
    logic [31:0]     cycleCnt;
    logic            trigEvent, push, pop, full, lastPush;
    logic            doWrite, rdAdv, dropEv;

    assign trigEvent = ret_valid && (!trig_en || ret_pc == trig_pc);
    assign push      = ret_valid && ((stateQ == ARMED && trigEvent) || stateQ == CAPTURE);
    assign capInc    = capCnt + 1'b1;
    // Dropped events are still counted, so the capture window is in retires, not entries.
    assign lastPush  = push && (cap_len != '0) && (capInc == cap_len);

    assign full      = (levelQ == LW'(DEPTH));
    assign out_valid = (levelQ != '0);
    assign pop       = out_valid && out_ready;
    assign dropEv    = push && full && !pop;
    assign doWrite   = push && (!full || pop || (OVERWRITE != 0));
    // Overwrite on full: the oldest entry is discarded by advancing the read pointer too.
    assign rdAdv     = pop || ((OVERWRITE != 0) && dropEv);

    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            ARMED:   if (trigEvent) stateNext = lastPush ? DONE : CAPTURE;
            CAPTURE: if (lastPush) stateNext = DONE;
            default: stateNext = stateQ;
        endcase
        if (arm) stateNext = ARMED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= IDLE;
            capCnt   <= '0;
            cycleCnt <= '0;
        end else begin
            stateQ   <= stateNext;
            cycleCnt <= cycleCnt + 32'd1;
            if (arm)       capCnt <= '0;
            else if (push) capCnt <= capInc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            levelQ <= '0;
            dropQ  <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (rdAdv)   rdPtr <= rdPtr + 1'b1;
            if (doWrite && !rdAdv)      levelQ <= levelQ + 1'b1;
            else if (!doWrite && rdAdv) levelQ <= levelQ - 1'b1;
            if (dropEv && dropQ != '1) dropQ <= dropQ + 1'b1;
        end
    end

    always_comb begin
        newEntry         = '0;
        newEntry.pc      = ret_pc;
        newEntry.instr   = ret_instr;
        newEntry.rdWe    = ret_rd_we;
        newEntry.rd      = ret_rd;
        newEntry.rdData  = ret_rd_data;
        newEntry.memWe   = ret_mem_we;
        newEntry.memSel  = ret_mem_sel;
        newEntry.memAddr = ret_mem_addr;
        newEntry.memData = ret_mem_data;
        newEntry.stamp   = cycleCnt;
    end

    always_ff @(posedge clk) begin
        if (doWrite && !reset && !flush) mem[wrPtr] <= newEntry;
    end

    assign head         = mem[rdPtr];
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign out_rd_we    = head.rdWe;
    assign out_rd       = head.rd;
    assign out_rd_data  = head.rdData;
    assign out_mem_we   = head.memWe;
    assign out_mem_sel  = head.memSel;
    assign out_mem_addr = head.memAddr;
    assign out_mem_data = head.memData;
    assign out_stamp    = head.stamp;
    assign state        = stateQ;
    assign drop_cnt     = dropQ;
    assign level        = levelQ;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench: two DEPTH=4 instances (drop vs overwrite) share stimulus; a
// per-instance scoreboard queue is checked on every pop.
module tb_retire_trace_buffer;
    localparam int XLEN = 32;
    localparam int CNTW = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdWe;
        logic [4:0]  rd;
        logic [31:0] rdData;
        logic        memWe;
        logic [3:0]  memSel;
        logic [31:0] memAddr;
        logic [31:0] memData;
        logic [31:0] stamp;
    } exp_t;

    logic clk = 0, reset = 1;
    logic ret_valid = 0, ret_rd_we = 0, ret_mem_we = 0;
    logic [31:0] ret_pc = 0, ret_instr = 0, ret_rd_data = 0, ret_mem_addr = 0, ret_mem_data = 0;
    logic [4:0]  ret_rd = 0;
    logic [3:0]  ret_mem_sel = 0;
    logic arm = 0, trig_en = 0, flush = 0, out_ready = 0;
    logic [31:0] trig_pc = 0;
    logic [CNTW-1:0] cap_len = 0;

    logic [1:0] ov [2];
    logic [31:0] oPc [2], oInstr [2], oRdData [2], oAddr [2], oData [2], oStamp [2];
    logic oRdWe [2], oMemWe [2];
    logic [4:0] oRd [2];
    logic [3:0] oSel [2];
    logic [1:0] oState [2];
    logic [CNTW-1:0] oDrop [2];
    logic [2:0] oLevel [2];
    logic oValid [2];

    exp_t q [2][$];
    logic [31:0] tbCyc = 0;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) tbCyc <= 0;
        else       tbCyc <= tbCyc + 1;
    end

    for (genvar g = 0; g < 2; g++) begin : gDut
        retire_trace_buffer #(.XLEN(XLEN), .DEPTH(4), .OVERWRITE(g), .CNTW(CNTW)) dut (
            .clk(clk), .reset(reset),
            .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
            .ret_rd_we(ret_rd_we), .ret_rd(ret_rd), .ret_rd_data(ret_rd_data),
            .ret_mem_we(ret_mem_we), .ret_mem_sel(ret_mem_sel),
            .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data),
            .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .cap_len(cap_len),
            .flush(flush), .out_valid(oValid[g]), .out_ready(out_ready),
            .out_pc(oPc[g]), .out_instr(oInstr[g]), .out_rd_we(oRdWe[g]), .out_rd(oRd[g]),
            .out_rd_data(oRdData[g]), .out_mem_we(oMemWe[g]), .out_mem_sel(oSel[g]),
            .out_mem_addr(oAddr[g]), .out_mem_data(oData[g]), .out_stamp(oStamp[g]),
            .state(oState[g]), .drop_cnt(oDrop[g]), .level(oLevel[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkEntry(input int d, input exp_t e);
        string p;
        p = $sformatf("dut%0d pc%0h", d, e.pc);
        check({p, " pc"},      64'(oPc[d]),     64'(e.pc));
        check({p, " instr"},   64'(oInstr[d]),  64'(e.instr));
        check({p, " rd"},      64'({oRdWe[d], oRd[d]}), 64'({e.rdWe, e.rd}));
        check({p, " rdData"},  64'(oRdData[d]), 64'(e.rdData));
        check({p, " mem"},     64'({oMemWe[d], oSel[d]}), 64'({e.memWe, e.memSel}));
        check({p, " memAddr"}, 64'(oAddr[d]),   64'(e.memAddr));
        check({p, " memData"}, 64'(oData[d]),   64'(e.memData));
        check({p, " stamp"},   64'(oStamp[d]),  64'(e.stamp));
    endtask

    // Pops are sampled at negedge, where inputs and head are settled for the next edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset && oValid[d] && out_ready) begin
                check($sformatf("dut%0d scoreboard nonempty at pop", d), 64'(q[d].size() != 0), 64'd1);
                if (q[d].size() != 0) checkEntry(d, q[d].pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doRetire(input logic [31:0] pc, input bit e0, input bit e1);
        exp_t e;
        ret_valid   = 1;
        ret_pc      = pc;
        ret_instr   = pc ^ 32'h0000_0013;
        ret_rd_we   = 1;
        ret_rd      = pc[6:2];
        ret_rd_data = ~pc;
        e.pc = pc; e.instr = ret_instr; e.rdWe = 1'b1; e.rd = pc[6:2]; e.rdData = ~pc;
        e.memWe = ret_mem_we; e.memSel = ret_mem_sel;
        e.memAddr = ret_mem_addr; e.memData = ret_mem_data; e.stamp = tbCyc;
        if (e0) q[0].push_back(e);
        if (e1) q[1].push_back(e);
        step(1);
        ret_valid = 0;
    endtask

    task automatic checkStatus(input string tag, input logic [1:0] st, input logic [2:0] lv,
                               input logic [CNTW-1:0] dr0, input logic [CNTW-1:0] dr1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s dut%0d state", tag, d), 64'(oState[d]), 64'(st));
            check($sformatf("%s dut%0d level", tag, d), 64'(oLevel[d]), 64'(lv));
            check($sformatf("%s dut%0d out_valid", tag, d), 64'(oValid[d]), 64'(lv != 0));
            check($sformatf("%s dut%0d drop_cnt", tag, d), 64'(oDrop[d]), 64'(d == 0 ? dr0 : dr1));
        end
    endtask

    task automatic pulseArm();
        arm = 1;
        step(1);
        arm = 0;
    endtask

    initial begin
        step(2);
        checkStatus("reset", 2'd0, 3'd0, 0, 0);
        reset = 0;
        step(1);

        // Immediate trigger, capture length 3
        trig_en = 0; cap_len = 3; out_ready = 1;
        pulseArm();
        check("arm -> ARMED", 64'(oState[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            doRetire(32'(i * 4), i < 3, i < 3);
            if (i == 2) check("DONE after third capture", 64'(oState[0]), 64'd3);
        end
        step(3);
        checkStatus("after caplen", 2'd3, 3'd0, 0, 0);

        // PC-match trigger, unlimited length
        trig_en = 1; trig_pc = 32'h20; cap_len = 0;
        pulseArm();
        doRetire(32'h18, 0, 0);
        doRetire(32'h1C, 0, 0);
        check("no trigger before match", 64'(oState[1]), 64'd1);
        doRetire(32'h20, 1, 1);
        doRetire(32'h24, 1, 1);
        step(3);
        checkStatus("pc trigger", 2'd2, 3'd0, 0, 0);

        // Fill past full with the sink stalled
        out_ready = 0;
        for (int i = 0; i < 6; i++) doRetire(32'h40 + 32'(i * 4), i < 4, 1);
        void'(q[1].pop_front());
        void'(q[1].pop_front());
        checkStatus("full", 2'd2, 3'd4, 2, 2);

        // Push and pop together on a full buffer
        out_ready = 1;
        doRetire(32'h58, 1, 1);
        out_ready = 0;
        checkStatus("full push+pop", 2'd2, 3'd4, 2, 2);
        out_ready = 1;
        step(6);
        out_ready = 0;
        checkStatus("drained", 2'd2, 3'd0, 2, 2);
        check("dut0 all expected popped", 64'(q[0].size()), 64'd0);
        check("dut1 all expected popped", 64'(q[1].size()), 64'd0);

        // Flush wins over a same-cycle push
        doRetire(32'h70, 1, 1);
        check("level before flush", 64'(oLevel[0]), 64'd1);
        flush = 1;
        doRetire(32'h74, 0, 0);
        flush = 0;
        q[0].delete();
        q[1].delete();
        checkStatus("flush", 2'd2, 3'd0, 0, 0);

        // Store retire fields, then reset mid-capture
        ret_mem_we = 1; ret_mem_sel = 4'b0011; ret_mem_addr = 32'h100; ret_mem_data = 32'hBEEF;
        doRetire(32'h80, 1, 1);
        ret_mem_we = 0; ret_mem_sel = 0; ret_mem_addr = 0; ret_mem_data = 0;
        out_ready = 1;
        step(1);
        out_ready = 0;
        check("dut0 store popped", 64'(q[0].size()), 64'd0);
        doRetire(32'h84, 0, 0);
        check("in capture before reset", 64'(oState[0]), 64'd2);
        check("entry held before reset", 64'(oLevel[1]), 64'd1);
        reset = 1;
        step(1);
        reset = 0;
        q[0].delete();
        q[1].delete();
        checkStatus("mid-capture reset", 2'd0, 3'd0, 0, 0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Parametrised, synthesizable trace capture block that records retired-instruction events of the pipelined RISC-V core (PC, instruction, register writeback, data-memory write) into a circular buffer.
- Entries drain through a valid/ready port.
- Adds an arm/trigger/capture-length state machine, selectable stop-on-full or overwrite-oldest modes, a drop counter and a cycle timestamp.
- Sits beside the core's writeback stage; feeds a debug or trace sink.

Parameters:
- XLEN, 32, data/address width of PC, instruction, result, address and write data.
- DEPTH, 16, buffer entries; must be a power of 2, ≥2.
- OVERWRITE, 0, 0 = drop new events when full; 1 = overwrite oldest entry when full.
- CNTW, 16, width of drop counter and capture-length fields.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ret_valid  in  1  an instruction retires this cycle.
- ret_pc  in  XLEN  PC of retiring instruction.
- ret_instr  in  32  instruction word.
- ret_rd_we  in  1  register write enable (RegWrite).
- ret_rd  in  5  destination register.
- ret_rd_data  in  XLEN  writeback value.
- ret_mem_we  in  1  MemWrite.
- ret_mem_sel  in  4  MemWriteSelect byte enables.
- ret_mem_addr  in  XLEN  DataAdr.
- ret_mem_data  in  XLEN  WriteData.
- arm  in  1  pulse: enter ARMED.
- trig_en  in  1  1 = wait for PC match; 0 = trigger on the next retire.
- trig_pc  in  XLEN  trigger PC.
- cap_len  in  CNTW  entries to capture after trigger; 0 = unlimited.
- flush  in  1  empty buffer, clear drop_cnt.
- out_valid  out  1  entry available.
- out_ready  in  1  sink accepts entry.
- out_pc, out_instr, out_rd_we, out_rd, out_rd_data, out_mem_we, out_mem_sel, out_mem_addr, out_mem_data  out  (as inputs)  head entry fields.
- out_stamp  out  32  cycle-counter value at capture.
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- drop_cnt  out  CNTW  saturating count of lost events.
- level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: state IDLE; pointers, level, drop_cnt, captured count and cycle counter all 0; out_valid 0.
- Cycle counter: free-running, wraps at 2^32.
- FSM transitions:
  - IDLE -> ARMED on arm.
  - ARMED -> CAPTURE on a trigger event: ret_valid && (!trig_en || ret_pc==trig_pc). The triggering retire is itself captured.
  - CAPTURE -> DONE when captured count reaches cap_len (cap_len≠0). The final push occurs in the same cycle as the transition.
  - DONE holds until arm.
  - arm in any state -> ARMED and clears captured count; FIFO contents are kept.
- push = ret_valid && (trigger event in ARMED, or state==CAPTURE).
- Event latency: an entry pushed at edge N is visible at the head by N+1 if the buffer was empty.
- Pop: occurs when out_valid && out_ready. out_valid = (level≠0). Head fields are read combinationally at the read pointer and are stable while out_valid && !out_ready.
- Full, OVERWRITE=0:
  - push is accepted if a pop occurs in the same cycle; otherwise the event is dropped and drop_cnt is incremented.
  - Dropped events still count toward cap_len.
- Full, OVERWRITE=1:
  - push without pop: write at wr_ptr, advance both pointers, level unchanged, drop_cnt incremented.
  - push with pop: normal operation, no drop.
- Empty with push: no pop possible that cycle (out_valid=0).
- Pointer arithmetic: pointers wrap modulo DEPTH; level is kept separately to distinguish full from empty.
- drop_cnt saturates at 2^CNTW−1.
- flush: pointers, level and drop_cnt go to 0; overrides a same-cycle push/pop; state and captured count are unaffected.
- reset mid-capture: everything returns to reset values on the next edge; in-flight entries are lost.

Test Plan:
- arm, trig_en=0, cap_len=3, ret_valid for 5 cycles with PC 0x0,0x4,…,0x10, out_ready=1 -> entries 0x0,0x4,0x8 emitted in order; state DONE after the third; out_stamp increases by 1 each entry.
- trig_en=1, trig_pc=0x20, retires 0x18,0x1C,0x20,0x24, cap_len=0 -> first entry 0x20, then 0x24; state stays CAPTURE.
- OVERWRITE=0, DEPTH=4, out_ready=0, 6 retires -> level=4, drop_cnt=2; drained PCs are the first 4.
- OVERWRITE=1, DEPTH=4, same stimulus -> level=4, drop_cnt=2; drained PCs are retires 3–6.
- Full buffer with push and pop in the same cycle -> no drop, level stays 4. flush in the same cycle as a push -> level=0, drop_cnt=0, out_valid=0 next cycle.
- Store retire (mem_we=1, sel=4'b0011, addr 0x100, data 0xBEEF) followed by reset asserted mid-CAPTURE -> entry fields match; after reset, state IDLE and level=0.
